// File: rtl/adc_sampler_if.sv
// Control and converter-side signals of the serial ADC front end.
// The slave modport faces adc_sampler. The master modport faces the controller and converter.
interface adc_sampler_if #(
   parameter int unsigned DATA_W = 12
);
   logic              en;
   logic              start;
   logic              sdata_adc;
   logic              cs;
   logic              sclk_adc;
   logic              busy;
   logic [DATA_W-1:0] sample_raw;
   logic [DATA_W-1:0] sample;
   logic              sample_valid;

   modport master (
      output en,
      output start,
      output sdata_adc,
      input  cs,
      input  sclk_adc,
      input  busy,
      input  sample_raw,
      input  sample,
      input  sample_valid
   );

   modport slave (
      input  en,
      input  start,
      input  sdata_adc,
      output cs,
      output sclk_adc,
      output busy,
      output sample_raw,
      output sample,
      output sample_valid
   );
endinterface

// File: rtl/adc_sampler.sv
// Serial ADC front end: it generates cs/sclk_adc, shifts in one frame and emits an offset-removed sample.
// Define ADC_SAMPLER_AVG_EN to average 2^AVG_LOG2 frames per output strobe.
module adc_sampler #(
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned QUIET_CYCLES = 4,
   parameter int unsigned AVG_LOG2     = 2
) (
   input logic          clk,
   input logic          rst,
   adc_sampler_if.slave bus
);

   localparam int unsigned PhW  = $clog2(2 * CLK_DIV);
   localparam int unsigned BitW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int unsigned QW   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

   localparam logic [PhW-1:0]    PhLast   = PhW'(2 * CLK_DIV - 1);
   localparam logic [PhW-1:0]    PhHalf   = PhW'(CLK_DIV);
   localparam logic [BitW-1:0]   BitLast  = BitW'(FRAME_BITS - 1);
   localparam logic [QW-1:0]     QLast    = QW'((QUIET_CYCLES > 0) ? QUIET_CYCLES - 1 : 0);
   localparam logic [DATA_W-1:0] MidScale = {1'b1, {(DATA_W - 1){1'b0}}};

   if (DATA_W < 2 || FRAME_BITS < DATA_W || CLK_DIV < 1 || AVG_LOG2 > 16) begin : g_param_check
      $error("adc_sampler: invalid parameter combination");
   end

   typedef enum logic [1:0] {StIdle, StConv, StDone, StQuiet} state_e;

   state_e            state_q, state_d;
   logic [PhW-1:0]    ph_q, ph_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [QW-1:0]     quiet_q, quiet_d;
   logic [DATA_W-2:0] shift_q, shift_d;
   logic              pending_q, pending_d;

   logic              cs_q, cs_d;
   logic              sclk_q, sclk_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] raw_q, raw_d;
   logic [DATA_W-1:0] sample_q, sample_d;

   logic              last_edge;
   logic              conv_entry;
   logic              go_next;
   logic [DATA_W-1:0] raw_new;

   // The edge that samples the final frame bit also ends the conversion.
   assign last_edge  = (state_q == StConv) && (ph_q == PhLast) && (bit_q == BitLast);
   assign conv_entry = (state_d == StConv) && (state_q != StConv);
   assign go_next    = bus.en || pending_q;
   assign raw_new    = {shift_q, bus.sdata_adc};

`ifdef ADC_SAMPLER_AVG_EN
   localparam int unsigned     AccW    = DATA_W + AVG_LOG2;
   localparam int unsigned     CntW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

   logic [AccW-1:0] acc_q, acc_d, acc_sum;
   logic [CntW-1:0] cnt_q, cnt_d;

   // The sum of 2^AVG_LOG2 full-scale samples fits exactly in AccW bits.
   assign acc_sum = acc_q + AccW'(raw_new);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start || go_next) begin
               state_d = StConv;
            end
         end
         StConv: begin
            if (last_edge) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (QUIET_CYCLES == 0) begin
               state_d = go_next ? StConv : StIdle;
            end else begin
               state_d = StQuiet;
            end
         end
         StQuiet: begin
            if (quiet_q == QLast) begin
               state_d = go_next ? StConv : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ph_d      = '0;
      bit_d     = '0;
      quiet_d   = '0;
      shift_d   = shift_q;
      pending_d = pending_q;

      if (state_q == StConv && state_d == StConv) begin
         if (ph_q == PhLast) begin
            bit_d = bit_q + 1'b1;
         end else begin
            ph_d  = ph_q + 1'b1;
            bit_d = bit_q;
         end
      end

      if (state_q == StConv && ph_q == PhLast) begin
         shift_d = raw_new[DATA_W-2:0];
      end

      if (state_q == StQuiet && state_d == StQuiet) begin
         quiet_d = quiet_q + 1'b1;
      end

      // Only one request is queued. Any start that coincides with CONV entry is absorbed by that entry.
      if (conv_entry) begin
         pending_d = 1'b0;
      end else if (bus.start && state_q != StIdle) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      cs_d    = (state_d != StConv);
      sclk_d  = (state_d != StConv) || (ph_d < PhHalf);
      busy_d  = (state_d != StIdle);
      valid_d = 1'b0;
      raw_d   = raw_q;
`ifdef ADC_SAMPLER_AVG_EN
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (last_edge) begin
         if (cnt_q == CntLast) begin
            valid_d = 1'b1;
            raw_d   = DATA_W'(acc_sum >> AVG_LOG2);
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
`else
      if (last_edge) begin
         valid_d = 1'b1;
         raw_d   = raw_new;
      end
`endif
      // Inverting the MSB equals subtracting mid-scale in two's complement.
      sample_d = {~raw_d[DATA_W-1], raw_d[DATA_W-2:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q      <= '0;
         bit_q     <= '0;
         quiet_q   <= '0;
         shift_q   <= '0;
         pending_q <= 1'b0;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b1;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         raw_q     <= MidScale;
         sample_q  <= '0;
      end else begin
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         quiet_q   <= quiet_d;
         shift_q   <= shift_d;
         pending_q <= pending_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         raw_q     <= raw_d;
         sample_q  <= sample_d;
      end
   end

`ifdef ADC_SAMPLER_AVG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
`endif

   assign bus.cs           = cs_q;
   assign bus.sclk_adc     = sclk_q;
   assign bus.busy         = busy_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_raw   = raw_q;
   assign bus.sample       = sample_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: a converter model, a frame-timeline reference model with per-cycle compare,
// and directed frames with hand-computed expectations.
module tb_adc_sampler;
   localparam int unsigned DATA_W       = 12;
   localparam int unsigned FRAME_BITS   = 16;
   localparam int unsigned CLK_DIV      = 2;
   localparam int unsigned QUIET_CYCLES = 4;
   localparam int unsigned AVG_LOG2     = 2;
   localparam int unsigned ConvLen      = 2 * FRAME_BITS * CLK_DIV;
   localparam int unsigned SeqLen       = ConvLen + QUIET_CYCLES;
   localparam logic [DATA_W-1:0] Mid    = DATA_W'(1 << (DATA_W - 1));

   logic clk = 1'b0;
   logic rst = 1'b1;
   adc_sampler_if #(.DATA_W(DATA_W)) bus ();

   adc_sampler #(
      .DATA_W       (DATA_W),
      .FRAME_BITS   (FRAME_BITS),
      .CLK_DIV      (CLK_DIV),
      .QUIET_CYCLES (QUIET_CYCLES),
      .AVG_LOG2     (AVG_LOG2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [FRAME_BITS-1:0] adc_q[$];
   logic [FRAME_BITS-1:0] mdl_q[$];

   task automatic push(input logic [FRAME_BITS-1:0] w);
      adc_q.push_back(w);
      mdl_q.push_back(w);
   endtask

   // The converter model and the waveform monitor. Data changes on the clk edge opposite to sampling.
   logic [FRAME_BITS-1:0] cur_word = '0;
   int   k = 0;
   logic prev_cs = 1'b1, prev_sclk = 1'b1;
   int   cyc = 0, n_fall = 0, n_valid = 0, last_fall = 0, fall_gap = 0;
   int   low_run = 0, last_low_run = 0, rises = 0, last_rises = 0, high_run = 0, last_high_run = 0;

   always @(negedge clk) begin
      cyc++;
      if (bus.cs === 1'b0 && prev_cs !== 1'b0) begin
         cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
         k = 0;
         n_fall++;
         fall_gap = cyc - last_fall;
         last_fall = cyc;
         last_high_run = high_run;
         low_run = 0;
         rises = 0;
      end
      if (prev_cs === 1'b0 && prev_sclk === 1'b0 && bus.sclk_adc === 1'b1) begin
         rises++;
         if (bus.cs === 1'b0) k++;
      end
      if (bus.cs === 1'b0) low_run++;
      if (bus.cs === 1'b1 && prev_cs === 1'b0) begin
         last_low_run = low_run;
         last_rises = rises;
         high_run = 0;
      end
      if (bus.cs === 1'b1) high_run++;
      if (bus.cs !== 1'b0) k = 0;
      if (bus.sample_valid === 1'b1) n_valid++;
      bus.sdata_adc = (k < FRAME_BITS) ? cur_word[FRAME_BITS-1-k] : 1'b0;
      prev_cs = bus.cs;
      prev_sclk = bus.sclk_adc;
   end

   // The reference model tracks position in the frame timeline. Position 0 is the first cs-low cycle.
   bit                    m_act = 1'b0, m_pend = 1'b0, m_vfr = 1'b0;
   int unsigned           m_t = 0;
   int unsigned           m_n = 0;
   logic [DATA_W-1:0]     m_raw = Mid;
   logic [FRAME_BITS-1:0] m_word = '0;
   logic [DATA_W+AVG_LOG2-1:0] m_sum = '0;

   task automatic m_begin();
      m_t = 0;
      m_pend = 1'b0;
      m_word = (mdl_q.size() > 0) ? mdl_q.pop_front() : '0;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_act = 1'b0; m_pend = 1'b0; m_raw = Mid; m_sum = '0; m_n = 0; m_vfr = 1'b0;
      end else if (!m_act) begin
         if (bus.start || bus.en || m_pend) begin
            m_act = 1'b1;
            m_begin();
         end
      end else begin
         if (m_t == ConvLen - 1) begin
`ifdef ADC_SAMPLER_AVG_EN
            m_sum = m_sum + m_word[DATA_W-1:0];
            m_n++;
            m_vfr = (m_n == (1 << AVG_LOG2));
            if (m_vfr) begin
               m_raw = DATA_W'(m_sum / (1 << AVG_LOG2));
               m_sum = '0;
               m_n = 0;
            end
`else
            m_raw = m_word[DATA_W-1:0];
            m_vfr = 1'b1;
`endif
         end
         if (m_t == SeqLen) begin
            if (bus.en || m_pend) m_begin();
            else begin
               m_act = 1'b0;
               if (bus.start) m_pend = 1'b1;
            end
         end else begin
            m_t++;
            if (bus.start) m_pend = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         logic in_conv;
         logic [DATA_W-1:0] exp_sample;
         in_conv = m_act && (m_t < ConvLen);
         exp_sample = m_raw - Mid;
         check("cs", bus.cs, !in_conv);
         check("sclk_adc", bus.sclk_adc, !in_conv || ((m_t / CLK_DIV) % 2 == 0));
         check("busy", bus.busy, m_act);
         check("sample_valid", bus.sample_valid, m_act && (m_t == ConvLen) && m_vfr);
         check("sample_raw", bus.sample_raw, m_raw);
         check("sample", bus.sample, exp_sample);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int c = 0;
      while (bus.sample_valid !== 1'b1 && c < budget) begin
         step();
         c++;
      end
      check({name, "_valid_seen"}, bus.sample_valid, 1'b1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c = 0;
      while (bus.busy !== 1'b0 && c < budget) begin
         step();
         c++;
      end
      check({name, "_idle_seen"}, bus.busy, 1'b0);
   endtask

   task automatic wait_falls(input string name, input int target, input int budget);
      int c = 0;
      while (n_fall < target && c < budget) begin
         step();
         c++;
      end
      check({name, "_cs_fall_seen"}, n_fall, target);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      int v0;
      logic [FRAME_BITS-1:0] lit_words[3] = '{16'h0800, 16'h0000, 16'h0FFF};
      logic [DATA_W-1:0]     lit_samp[3]  = '{12'h000, 12'h800, 12'h7FF};
      bus.en = 1'b0;
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_on = 1'b1;
      step();
      check("rst_cs", bus.cs, 1'b1);
      check("rst_sclk", bus.sclk_adc, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_valid", bus.sample_valid, 1'b0);
      check("rst_raw", bus.sample_raw, 12'h800);
      check("rst_sample", bus.sample, 12'h000);
      rst = 1'b0;
      step();

`ifdef ADC_SAMPLER_AVG_EN
      v0 = n_valid;
      push(16'h0100); pulse_start(); wait_idle("avg1", 200);
      push(16'h0101); pulse_start(); wait_idle("avg2", 200);
      push(16'h0102); pulse_start(); wait_idle("avg3", 200);
      check("avg_no_strobe_1to3", n_valid - v0, 0);
      push(16'h0104); pulse_start();
      wait_valid("avg4", 200);
      check("avg_raw", bus.sample_raw, 12'h101);
      check("avg_sample", bus.sample, 12'h901);
      wait_idle("avg4", 200);
      check("avg_strobe_count", n_valid - v0, 1);
`else
      // Single-shot frame 0x0ABC.
      push(16'h0ABC);
      pulse_start();
      wait_valid("abc", 200);
      check("abc_raw", bus.sample_raw, 12'hABC);
      check("abc_sample", bus.sample, 12'h2BC);
      check("abc_cs_low_cycles", last_low_run, 64);
      check("abc_sclk_rises", last_rises, 16);
      step();
      check("abc_valid_one_cycle", bus.sample_valid, 1'b0);
      wait_idle("abc", 200);

      // Offset removal at mid-scale and both ends of the range.
      for (int i = 0; i < 3; i++) begin
         push(lit_words[i]);
         pulse_start();
         wait_valid("lit", 200);
         check($sformatf("lit%0d_sample", i), bus.sample, lit_samp[i]);
         wait_idle("lit", 200);
      end

      // Continuous mode, then en drops at t=10 of the third frame.
      push(16'h0123); push(16'h0456); push(16'h0789);
      f0 = n_fall;
      bus.en = 1'b1;
      wait_falls("cont2", f0 + 2, 300);
      check("cont_fall_gap", fall_gap, 69);
      check("cont_cs_high_gap", last_high_run, 5);
      wait_falls("cont3", f0 + 3, 300);
      repeat (10) step();
      bus.en = 1'b0;
      wait_valid("cont3", 200);
      check("cont3_raw", bus.sample_raw, 12'h789);
      repeat (100) step();
      check("cont_stop_frames", n_fall - f0, 3);
      check("cont_stop_idle", bus.busy, 1'b0);

      // Three starts during one busy frame give exactly two frames.
      push(16'h0111); push(16'h0222);
      f0 = n_fall;
      v0 = n_valid;
      pulse_start();
      repeat (5) step();
      pulse_start();
      repeat (5) step();
      pulse_start();
      wait_idle("multi", 400);
      check("multi_frames", n_fall - f0, 2);
      check("multi_valids", n_valid - v0, 2);
      check("multi_gap", fall_gap, 69);
      check("multi_raw", bus.sample_raw, 12'h222);

      // Reset at t=30 of a frame.
      push(16'h0AAA);
      f0 = n_fall;
      v0 = n_valid;
      pulse_start();
      wait_falls("rstmid", f0 + 1, 50);
      repeat (30) step();
      rst = 1'b1;
      step();
      check("rstmid_cs", bus.cs, 1'b1);
      check("rstmid_sclk", bus.sclk_adc, 1'b1);
      check("rstmid_raw", bus.sample_raw, 12'h800);
      rst = 1'b0;
      repeat (100) step();
      check("rstmid_no_valid", n_valid - v0, 0);
      push(16'h0321);
      pulse_start();
      wait_valid("after_rst", 200);
      check("after_rst_raw", bus.sample_raw, 12'h321);
      check("after_rst_cs_low", last_low_run, 64);
      wait_idle("after_rst", 200);
`endif
      repeat (5) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
